// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus debounce qualifier for a raw asynchronous level
//
// Brings a raw, possibly bouncing level into the clk domain and accepts a new
// level only after DEBOUNCE_CYCLES consecutive synchronized samples agree.
//
// Parameters:
//   SYNC_STAGES     - synchronizer depth (2..4)
//   DEBOUNCE_CYCLES - consecutive samples needed to accept a change (2..65535)
//
// Ports:
//   clk    - clock, all state updates on posedge
//   reset  - asynchronous, active-high reset
//   din    - raw asynchronous level
//   enable - 1 allows level changes to be qualified
//   q      - debounced level (registered)
//   rise   - one-cycle pulse when q goes 0->1 (registered)
//   fall   - one-cycle pulse when q goes 1->0 (registered)
//   busy   - high while a candidate change is being qualified

module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic enable,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    LOW_STABLE,
    PEND_HIGH,
    HIGH_STABLE,
    PEND_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   q_q;
  logic                   rise_q;
  logic                   fall_q;

  // Bit 0 takes the raw input; the top bit is the synchronized sample.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-set below.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW_STABLE: begin
          q_q <= 1'b0;
          if (s && enable) begin
            state_q <= PEND_HIGH;
            cnt_q   <= CNT_ONE;
          end
        end
        PEND_HIGH: begin
          // Any low sample or loss of enable throws the candidate away.
          if (!enable || !s) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HIGH_STABLE;
            q_q     <= 1'b1;
            rise_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HIGH_STABLE: begin
          q_q <= 1'b1;
          if (!s && enable) begin
            state_q <= PEND_LOW;
            cnt_q   <= CNT_ONE;
          end
        end
        PEND_LOW: begin
          if (!enable || s) begin
            state_q <= HIGH_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW_STABLE;
            q_q     <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= LOW_STABLE;
          cnt_q   <= '0;
          q_q     <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == PEND_HIGH) || (state_q == PEND_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync

module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic enable = 1'b0;
  logic q, rise, fall, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: din samples seen at each edge, and the length of the current
  // streak of enabled samples that disagree with the accepted level.
  bit samples[$];
  int run;
  bit mq, mr, mf, mb;

  debounce_sync #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .din(din), .enable(enable),
    .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    samples.delete();
    for (int i = 0; i < SYNC; i++) samples.push_back(1'b0);
    run = 0;
    mq = 0; mr = 0; mf = 0; mb = 0;
  endtask

  task automatic model_step();
    bit s_used;
    s_used = samples.pop_front();
    samples.push_back(din);
    mr = 0; mf = 0;
    if (enable && (s_used != mq)) run++;
    else run = 0;
    if (run == DEB) begin
      mq = ~mq;
      mr = mq;
      mf = ~mq;
      run = 0;
    end
    mb = (run != 0);
  endtask

  // Drive inputs at negedge, advance one posedge, update the model, settle.
  task automatic tick(input bit d, input bit e, input bit r);
    @(negedge clk);
    din = d; enable = e; reset = r;
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    for (int k = 1; k <= 3; k++) begin
      tick(1, 1, 1);
      n_checks++;
      if ({q, rise, fall, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got q,r,f,b=%b want 0000", k, {q, rise, fall, busy});
      end
    end
    for (int k = 1; k <= 7; k++) begin
      logic [3:0] exp;
      tick(1, 1, 0);
      exp = {(k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 1'b1 : 1'b0, 1'b0, (k >= 3 && k < 6) ? 1'b1 : 1'b0};
      n_checks++;
      if ({q, rise, fall, busy} !== exp) begin
        n_fail++;
        $display("FAIL first_rise edge=%0d got q,r,f,b=%b want %b", k, {q, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_fall();
    for (int k = 1; k <= 7; k++) begin
      logic [3:0] exp;
      tick(0, 1, 0);
      exp = {(k >= 6) ? 1'b0 : 1'b1, 1'b0, (k == 6) ? 1'b1 : 1'b0, (k >= 3 && k < 6) ? 1'b1 : 1'b0};
      n_checks++;
      if ({q, rise, fall, busy} !== exp) begin
        n_fail++;
        $display("FAIL clean_fall edge=%0d got q,r,f,b=%b want %b", k, {q, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    bit saw_busy = 0;
    for (int k = 1; k <= 10; k++) begin
      tick((k <= 3) ? 1'b1 : 1'b0, 1, 0);
      if (busy) saw_busy = 1;
      n_checks++;
      if ({q, rise} !== 2'b00) begin
        n_fail++;
        $display("FAIL glitch_q edge=%0d got q,rise=%b want 00", k, {q, rise});
      end
    end
    n_checks++;
    if (saw_busy !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy got seen=%b end=%b want seen=1 end=0", saw_busy, busy);
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    for (int t = 1; t <= 32; t++) begin
      bit d;
      d = (t > 20) ? 1'b1 : (((t - 1) / 2) % 2 == 0);
      tick(d, 1, 0);
      if (rise) rises++;
      n_checks++;
      if (q !== ((t >= 26) ? 1'b1 : 1'b0) || {q, rise, fall, busy} !== {mq, mr, mf, mb}) begin
        n_fail++;
        $display("FAIL bounce t=%0d got q,r,f,b=%b want q=%b model=%b", t, {q, rise, fall, busy},
                 (t >= 26), {mq, mr, mf, mb});
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_rises got %0d want 1", rises);
    end
  endtask

  task automatic test_enable();
    for (int k = 0; k < 8; k++) tick(0, 1, 0);
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_pre got q=%b want 0", q);
    end
    tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_pend got busy=%b want 1", busy);
    end
    for (int k = 1; k <= 6; k++) begin
      tick(1, 0, 0);
      n_checks++;
      if ({q, rise, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL enable_gated cyc=%0d got q,rise,busy=%b want 000", k, {q, rise, busy});
      end
    end
    for (int k = 1; k <= 5; k++) begin
      tick(1, 1, 0);
      n_checks++;
      if (q !== ((k >= 4) ? 1'b1 : 1'b0) || rise !== ((k == 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL enable_resume edge=%0d got q,rise=%b%b want %b%b", k, q, rise,
                 (k >= 4), (k == 4));
      end
    end
  endtask

  task automatic test_async_reset();
    n_checks++;
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre got q=%b want 1", q);
    end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({q, rise, fall, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_mid got q,r,f,b=%b want 0000", {q, rise, fall, busy});
    end
    tick(1, 1, 1); tick(1, 1, 1);
    n_checks++;
    if ({q, rise, fall, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_hold got q,r,f,b=%b want 0000", {q, rise, fall, busy});
    end
    for (int k = 1; k <= 6; k++) tick(1, 1, 0);
    n_checks++;
    if ({q, rise} !== 2'b11) begin
      n_fail++;
      $display("FAIL areset_resume got q,rise=%b want 11", {q, rise});
    end
  endtask

  task automatic test_random();
    int hold = 0;
    bit d = 0;
    for (int t = 0; t < 400; t++) begin
      bit e;
      if (hold == 0) begin
        d = ~d;
        hold = $urandom_range(1, 8);
      end
      hold--;
      e = ($urandom_range(0, 9) != 0);
      tick(d, e, 0);
      n_checks++;
      if ({q, rise, fall, busy} !== {mq, mr, mf, mb} || (rise & fall)) begin
        n_fail++;
        $display("FAIL random t=%0d got q,r,f,b=%b want %b", t, {q, rise, fall, busy},
                 {mq, mr, mf, mb});
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fall();
    test_glitch();
    test_bounce();
    test_enable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the team's D flip-flop storage stage and drives its d input.
- Takes a raw, asynchronous, possibly bouncing level (push-button, external strobe) and brings it into the clk domain through an N-stage synchronizer.
- Accepts a level change only after it has been stable for a programmable number of cycles.
- Produces a clean level plus single-cycle rise/fall pulses.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal 2..4).
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a new level (legal 2..65535).
- Internal counter width is derived as $clog2(DEBOUNCE_CYCLES)+1. It is not a parameter.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high reset.
- din, input, 1, raw asynchronous level.
- enable, input, 1, synchronous; 1 allows level changes to be qualified.
- q, output, 1, debounced level (registered).
- rise, output, 1, one-cycle pulse when q goes 0->1 (registered).
- fall, output, 1, one-cycle pulse when q goes 1->0 (registered).
- busy, output, 1, high while a candidate change is being qualified (decoded from state).

Behaviour:
- Reset is asserted on posedge reset and is asynchronous. On reset:
  - All synchronizer flops = 0.
  - state = LOW_STABLE, cnt = 0.
  - q = 0, rise = 0, fall = 0, busy = 0.
  - These values hold while reset is high. Reset mid-qualification discards the pending change with no pulse.
  - Reset while q=1 drops q to 0 immediately and does not pulse fall.
- Synchronizer:
  - Shift chain din -> stage0 -> ... -> stage[SYNC_STAGES-1].
  - s = last stage. s lags din by SYNC_STAGES edges.
  - The chain runs regardless of enable.
- FSM states: LOW_STABLE, PEND_HIGH, HIGH_STABLE, PEND_LOW.
- LOW_STABLE:
  - q = 0.
  - If s=1 and enable=1: go to PEND_HIGH, cnt <= 1. Otherwise stay.
- PEND_HIGH:
  - If enable=0 or s=0: go to LOW_STABLE, cnt <= 0. This is glitch rejection; no pulse.
  - Else if cnt == DEBOUNCE_CYCLES-1: go to HIGH_STABLE, q <= 1, rise <= 1, cnt <= 0.
  - Else cnt <= cnt+1.
- HIGH_STABLE and PEND_LOW mirror the above:
  - Polarity of s is inverted.
  - Exit from PEND_LOW sets q <= 0 and fall <= 1.
- rise and fall are high for exactly one cycle. They are cleared on the following edge unless re-set, which is impossible because the minimum time between accepted changes is DEBOUNCE_CYCLES >= 2.
- busy = 1 exactly when state is PEND_HIGH or PEND_LOW.
- Latency: din step held stable, captured at edge 1 → q changes at edge SYNC_STAGES+DEBOUNCE_CYCLES. The rise/fall pulse is asserted in the same cycle that q changes.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1.
  - No wrap is possible; cnt is reset to 0 on every state exit.
- enable=0 in a stable state: q holds and no transition starts.
- enable=0 in a pending state: aborts to the originating stable state on that edge.
- rise and fall are never asserted simultaneously.

Test Plan:
Default parameters (SYNC_STAGES=2, DEBOUNCE_CYCLES=4), 10 ns clock.
1. Reset held 3 cycles with din=1 → q=0, rise=0, fall=0, busy=0 throughout. Release with din=1, enable=1 → busy=1 after edge 3, q=1 and rise=1 after edge 6, rise=0 after edge 7.
2. Clean fall from q=1: din 1->0 held → busy after edge 3, q=0 and fall=1 for one cycle after edge 6; rise stays 0.
3. Glitch: from q=0, din=1 for 3 cycles then 0 → busy pulses, q stays 0, rise never asserts, state returns to LOW_STABLE.
4. Bounce: din toggles every 2 cycles for 20 cycles, then settles at 1 → q=0 during toggling; q=1 exactly 6 edges after the last toggle; a single rise pulse total.
5. Enable gating: din=1 held, enable dropped during PEND_HIGH (cnt=2) → returns to LOW_STABLE, q=0. With enable held 0, q stays 0. When enable returns to 1, q rises 4 edges later.
6. Async reset while q=1 and mid-cycle (not on an edge) → q drops to 0 within the same time step, no fall pulse, busy=0; normal operation resumes after release.
